// File: rtl/display_pkg.sv
// display_pkg: shared constants, channel indices, FSM encoding and digit type
// for the display BCD sequencer.
package display_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BCD_N = 10;
  localparam logic [1:0] CH_PC = 2'd0;
  localparam logic [1:0] CH_R1 = 2'd1;
  localparam logic [1:0] CH_R2 = 2'd2;
  localparam logic [1:0] CH_PR = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE, S_DONE} state_e;
  typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/bcd_add3_shift.sv
// bcd_add3_shift: one double-dabble step, adjusting each BCD nibble >= 5 by +3
// and then shifting {bcd, bin} left by one.
module bcd_add3_shift #(
  parameter int DATA_W = 32,
  parameter int BCD_N = 10
) (
  input  logic [4*BCD_N+DATA_W-1:0] din_i,
  output logic [4*BCD_N+DATA_W-1:0] dout_o
);
  logic [4*BCD_N-1:0] adj;
  for (genvar g = 0; g < BCD_N; g++) begin : g_nib
    logic [3:0] nib;
    assign nib = din_i[DATA_W+4*g +: 4];
    assign adj[4*g +: 4] = nib >= 4'd5 ? nib + 4'd3 : nib;
  end
  assign dout_o = {adj[4*BCD_N-2:0], din_i[DATA_W-1:0], 1'b0};
endmodule

// File: rtl/display_bcd_sequencer.sv
// display_bcd_sequencer: snapshots four values on start and converts each in turn
// to tens/ones digits plus overflow, committing all outputs together.
module display_bcd_sequencer
  import display_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BCD_N = DEF_BCD_N
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] read_register_1,
  input  logic [DATA_W-1:0] read_register_2,
  input  logic [DATA_W-1:0] print_register,
  output logic              busy,
  output logic              done,
  output bcd_digit_t        pc_tens,
  output bcd_digit_t        pc_ones,
  output bcd_digit_t        r1_tens,
  output bcd_digit_t        r1_ones,
  output bcd_digit_t        r2_tens,
  output bcd_digit_t        r2_ones,
  output bcd_digit_t        pr_tens,
  output bcd_digit_t        pr_ones,
  output logic [3:0]        ovf
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  state_e state_q, state_d;
  logic [1:0] ch_q, ch_d;
  logic [DATA_W-1:0] snap_q [4];
  logic [DATA_W-1:0] snap_d [4];
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [4*BCD_N-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bcd_digit_t sh_tens_q [4];
  bcd_digit_t sh_tens_d [4];
  bcd_digit_t sh_ones_q [4];
  bcd_digit_t sh_ones_d [4];
  bcd_digit_t out_tens_q [4];
  bcd_digit_t out_tens_d [4];
  bcd_digit_t out_ones_q [4];
  bcd_digit_t out_ones_d [4];
  logic [3:0] sh_ovf_q, sh_ovf_d, out_ovf_q, out_ovf_d;
  logic [4*BCD_N+DATA_W-1:0] step;
  bcd_add3_shift #(.DATA_W(DATA_W), .BCD_N(BCD_N)) u_step (
    .din_i  ({bcd_q, bin_q}),
    .dout_o (step)
  );
  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    snap_d = snap_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    sh_tens_d = sh_tens_q;
    sh_ones_d = sh_ones_q;
    sh_ovf_d = sh_ovf_q;
    out_tens_d = out_tens_q;
    out_ones_d = out_ones_q;
    out_ovf_d = out_ovf_q;
    case (state_q)
      S_IDLE: if (start) begin
        snap_d[CH_PC] = pc;
        snap_d[CH_R1] = read_register_1;
        snap_d[CH_R2] = read_register_2;
        snap_d[CH_PR] = print_register;
        ch_d = CH_PC;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        bin_d = snap_q[ch_q];
        bcd_d = '0;
        cnt_d = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        {bcd_d, bin_d} = step;
        cnt_d = cnt_q + CNT_W'(1);
        state_d = cnt_q == CNT_W'(DATA_W - 1) ? S_STORE : S_SHIFT;
      end
      S_STORE: begin
        sh_tens_d[ch_q] = bcd_q[7:4];
        sh_ones_d[ch_q] = bcd_q[3:0];
        sh_ovf_d[ch_q] = |bcd_q[4*BCD_N-1:8];
        // Last channel commits every shadow, including the one just written, in one edge
        if (ch_q == CH_PR) begin
          out_tens_d = sh_tens_d;
          out_ones_d = sh_ones_d;
          out_ovf_d = sh_ovf_d;
          state_d = S_DONE;
        end else begin
          ch_d = ch_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q <= '0;
      snap_q <= '{default: '0};
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      sh_tens_q <= '{default: '0};
      sh_ones_q <= '{default: '0};
      sh_ovf_q <= '0;
      out_tens_q <= '{default: '0};
      out_ones_q <= '{default: '0};
      out_ovf_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      snap_q <= snap_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      sh_tens_q <= sh_tens_d;
      sh_ones_q <= sh_ones_d;
      sh_ovf_q <= sh_ovf_d;
      out_tens_q <= out_tens_d;
      out_ones_q <= out_ones_d;
      out_ovf_q <= out_ovf_d;
    end
  end
  assign busy = state_q inside {S_LOAD, S_SHIFT, S_STORE};
  assign done = state_q == S_DONE;
  assign pc_tens = out_tens_q[CH_PC];
  assign pc_ones = out_ones_q[CH_PC];
  assign r1_tens = out_tens_q[CH_R1];
  assign r1_ones = out_ones_q[CH_R1];
  assign r2_tens = out_tens_q[CH_R2];
  assign r2_ones = out_ones_q[CH_R2];
  assign pr_tens = out_tens_q[CH_PR];
  assign pr_ones = out_ones_q[CH_PR];
  assign ovf = out_ovf_q;
endmodule

// File: tb/tb_display_bcd_sequencer.sv
// tb_display_bcd_sequencer: directed checks of conversion, latency, snapshot,
// reset abort and start handling around DONE.
module tb_display_bcd_sequencer;
  logic clk = 0, reset = 0, start = 0;
  logic [31:0] pc = 0, r1 = 0, r2 = 0, pr = 0;
  logic busy, done;
  logic [3:0] pc_t, pc_o, r1_t, r1_o, r2_t, r2_o, pr_t, pr_o, ovf;
  logic [31:0] digits;
  int total = 0, bad = 0;
  int dc, bc, cnt;
  always #5 clk = ~clk;
  display_bcd_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .pc(pc), .read_register_1(r1), .read_register_2(r2), .print_register(pr),
    .busy(busy), .done(done),
    .pc_tens(pc_t), .pc_ones(pc_o), .r1_tens(r1_t), .r1_ones(r1_o),
    .r2_tens(r2_t), .r2_ones(r2_o), .pr_tens(pr_t), .pr_ones(pr_o),
    .ovf(ovf)
  );
  assign digits = {pc_t, pc_o, r1_t, r1_o, r2_t, r2_o, pr_t, pr_o};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_in(input logic [31:0] a, b, c, d);
    pc = a; r1 = b; r2 = c; pr = d;
  endtask
  // Pulses start, then waits for done; poke>0 re-pulses start and scrambles inputs at that cycle
  task automatic go(input int poke, output int done_cyc, output int busy_cnt);
    start = 1;
    tick();
    start = 0;
    done_cyc = 0;
    busy_cnt = 0;
    for (int n = 1; n <= 400 && done_cyc == 0; n++) begin
      if (busy) busy_cnt++;
      if (done) done_cyc = n;
      if (done_cyc == 0) begin
        if (poke != 0 && n == poke) begin start = 1; set_in(99, 99, 99, 99); end
        tick();
        start = 0;
      end
    end
  endtask
  task automatic count_done(input int cycles, output int n_done);
    n_done = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (done) n_done++;
    end
  endtask
  initial begin
    reset = 1;
    tick();
    tick();
    chk("reset_digits", digits, 32'h0);
    chk("reset_ovf", {28'h0, ovf}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    reset = 0;
    tick();
    set_in(7, 42, 99, 0);
    go(0, dc, bc);
    chk("t2_done_cycle", dc, 137);
    chk("t2_busy_cycles", bc, 136);
    chk("t2_digits", digits, 32'h0742_9900);
    chk("t2_ovf", {28'h0, ovf}, 32'h0);
    tick();
    chk("t2_done_pulse", {31'h0, done}, 32'h0);
    chk("t2_idle_busy", {31'h0, busy}, 32'h0);
    chk("t2_hold", digits, 32'h0742_9900);
    set_in(0, 100, 55, 32'hFFFF_FFFF);
    go(0, dc, bc);
    chk("t3_done_cycle", dc, 137);
    chk("t3_digits", digits, 32'h0000_5595);
    chk("t3_ovf", {28'h0, ovf}, 32'hA);
    tick();
    set_in(3, 86, 250, 10);
    go(20, dc, bc);
    chk("t4_done_cycle", dc, 137);
    chk("t4_digits", digits, 32'h0386_5010);
    chk("t4_ovf", {28'h0, ovf}, 32'h4);
    count_done(150, cnt);
    chk("t4_no_extra_done", cnt, 0);
    chk("t4_idle_busy", {31'h0, busy}, 32'h0);
    set_in(11, 22, 33, 44);
    start = 1;
    tick();
    start = 0;
    for (int n = 1; n < 50; n++) tick();
    chk("t5_busy_before_reset", {31'h0, busy}, 32'h1);
    reset = 1;
    tick();
    reset = 0;
    chk("t5_digits_zero", digits, 32'h0);
    chk("t5_ovf_zero", {28'h0, ovf}, 32'h0);
    chk("t5_busy_zero", {31'h0, busy}, 32'h0);
    chk("t5_done_zero", {31'h0, done}, 32'h0);
    count_done(150, cnt);
    chk("t5_no_done", cnt, 0);
    set_in(58, 1000, 9, 123456789);
    go(0, dc, bc);
    chk("t5_restart_cycle", dc, 137);
    chk("t5_restart_digits", digits, 32'h5800_0989);
    chk("t5_restart_ovf", {28'h0, ovf}, 32'hA);
    tick();
    set_in(1, 2, 3, 4);
    go(0, dc, bc);
    chk("t6a_digits", digits, 32'h0102_0304);
    start = 1;
    set_in(64, 17, 200, 31);
    tick();
    chk("t6_start_in_done_ignored", {31'h0, busy}, 32'h0);
    go(0, dc, bc);
    chk("t6_done_cycle", dc, 137);
    chk("t6_digits", digits, 32'h6417_0031);
    chk("t6_ovf", {28'h0, ovf}, 32'h4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
